// File: rtl/fp_fixed_pkg.sv
// FP32 field constants and operand classes shared by the float-to-fixed stream.
package fp_fixed_pkg;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} fp_class_e;
endpackage

// File: rtl/fp32_classify.sv
// Combinational split of an FP32 word into sign, exponent, mantissa (with hidden bit) and class.
module fp32_classify
    import fp_fixed_pkg::*;
(
    input  logic [31:0]      fp,
    output logic             sign,
    output logic [EXP_W-1:0] expo,
    output logic [MAN_W:0]   mant,
    output fp_class_e        cls
);
    logic man_nz;

    assign sign   = fp[31];
    assign expo   = fp[30:23];
    assign man_nz = |fp[22:0];
    assign mant   = {expo != '0, fp[22:0]};

    always_comb begin
        cls = NORMAL;
        if (expo == EXP_W'(EXP_MAX))
            cls = man_nz ? NAN : INF;
        else if (expo == '0)
            cls = man_nz ? DENORM : ZERO;
    end
endmodule

// File: rtl/fp_to_fixed_stream.sv
// Two-stage FP32 -> sign-magnitude fixed-point converter with valid/ready flow control.
// S1 classifies and aligns, S2 rounds, saturates and raises flags into the output registers.
module fp_to_fixed_stream
    import fp_fixed_pkg::*;
#(
    parameter int INT_W  = 1,
    parameter int FRAC_W = 19,
    parameter int ROUND  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       fp_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              sign_o,
    output logic [INT_W-1:0]  integer_o,
    output logic [FRAC_W-1:0] fractional_o,
    output logic              ovf_o,
    output logic              unf_o,
    output logic              nan_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);
    localparam int W      = INT_W + FRAC_W;
    localparam int STAGES = 2;

    logic [STAGES:1] vld_pipe;
    logic            s1_adv, s2_adv;

    logic             c_sign;
    logic [EXP_W-1:0] c_exp;
    logic [MAN_W:0]   c_mant;
    fp_class_e        c_cls;

    int               rsh;
    logic             a_ovf;
    logic [W:0]       a_vec;

    logic             s1_sign, s1_guard, s1_ovf;
    logic [W-1:0]     s1_mag;
    fp_class_e        s1_cls;

    logic [W:0]       rnd_sum;
    logic             n_sign, n_ovf, n_unf, n_nan;
    logic [W-1:0]     n_mag;

    assign s2_adv      = !vld_pipe[2] || out_ready_i;
    assign s1_adv      = !vld_pipe[1] || s2_adv;
    assign in_ready_o  = s1_adv;
    assign out_valid_o = vld_pipe[2];

    fp32_classify u_cls (
        .fp   (fp_i),
        .sign (c_sign),
        .expo (c_exp),
        .mant (c_mant),
        .cls  (c_cls)
    );

    // Mantissa sits above W+1 zero bits; the right shift drops it onto the
    // fixed-point grid with bit 0 as the guard. Out-of-range shifts give zero.
    always_comb begin
        a_ovf = (c_cls == NORMAL) && (int'(c_exp) >= BIAS + INT_W);
        rsh   = INT_W + BIAS + MAN_W - int'(c_exp);
        a_vec = '0;
        if (c_cls == NORMAL && !a_ovf)
            a_vec = (W+1)'({c_mant, {(W+1){1'b0}}} >> rsh);
    end

    // Half-away-from-zero on magnitude needs only the guard bit.
    always_comb begin
        rnd_sum = {1'b0, s1_mag} + (W+1)'((ROUND != 0) && s1_guard);
        n_sign  = s1_sign;
        n_mag   = '0;
        n_ovf   = 1'b0;
        n_unf   = 1'b0;
        n_nan   = 1'b0;
        case (s1_cls)
            NAN:    begin n_sign = 1'b0; n_nan = 1'b1; end
            INF:    begin n_ovf = 1'b1; n_mag = '1; end
            DENORM: n_unf = 1'b1;
            NORMAL: begin
                if (s1_ovf || rnd_sum[W]) begin
                    n_ovf = 1'b1;
                    n_mag = '1;
                end else begin
                    n_mag = rnd_sum[W-1:0];
                    n_unf = (rnd_sum[W-1:0] == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe     <= '0;
            s1_sign      <= 1'b0;
            s1_guard     <= 1'b0;
            s1_ovf       <= 1'b0;
            s1_mag       <= '0;
            s1_cls       <= ZERO;
            sign_o       <= 1'b0;
            integer_o    <= '0;
            fractional_o <= '0;
            ovf_o        <= 1'b0;
            unf_o        <= 1'b0;
            nan_o        <= 1'b0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid_i;
                if (in_valid_i) begin
                    s1_sign  <= c_sign;
                    s1_cls   <= c_cls;
                    s1_ovf   <= a_ovf;
                    s1_mag   <= a_vec[W:1];
                    s1_guard <= a_vec[0];
                end
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    sign_o       <= n_sign;
                    integer_o    <= n_mag[W-1:FRAC_W];
                    fractional_o <= n_mag[FRAC_W-1:0];
                    ovf_o        <= n_ovf;
                    unf_o        <= n_unf;
                    nan_o        <= n_nan;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_to_fixed_stream.sv
// Six converter configurations share one handshake stream; every result is compared to an arithmetic model.
module tb_fp_to_fixed_stream;
    localparam int NC = 6;
    localparam int CFG_IW [NC] = '{1, 1, 4, 4, 8, 8};
    localparam int CFG_FW [NC] = '{19, 19, 12, 12, 30, 30};
    localparam int CFG_RD [NC] = '{0, 1, 0, 1, 0, 1};

    localparam logic [31:0] D_FP [8] = '{32'h3F000000, 32'hBF400000, 32'h3FC00000, 32'h40000000,
                                         32'hFF800000, 32'h35800000, 32'h7FC00000, 32'h00000001};
    localparam logic        D_S  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [63:0] D_M0 [8] = '{64'h40000, 64'h60000, 64'hC0000, 64'hFFFFF,
                                         64'hFFFFF, 64'h0, 64'h0, 64'h0};
    localparam logic [63:0] D_M1 [8] = '{64'h40000, 64'h60000, 64'hC0000, 64'hFFFFF,
                                         64'hFFFFF, 64'h1, 64'h0, 64'h0};
    // flags ordered {ovf, unf, nan}
    localparam logic [2:0]  D_F0 [8] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b010, 3'b001, 3'b010};
    localparam logic [2:0]  D_F1 [8] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001, 3'b010};

    typedef struct {
        logic        sign;
        logic [63:0] mag;
        logic [2:0]  flg;
    } ref_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fp;
    logic        in_valid, out_ready;

    logic [63:0] got_mag  [NC];
    logic        got_sign [NC];
    logic [2:0]  got_flg  [NC];
    logic        got_ov   [NC];
    logic        got_ir   [NC];

    int          compared = 0;
    int          mismatched = 0;
    int          n_out = 0;
    logic [31:0] sb_q [$];
    logic        hold_prev = 1'b0;
    logic [63:0] prev_mag;
    logic [3:0]  prev_sf;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        logic [CFG_IW[g]-1:0] io;
        logic [CFG_FW[g]-1:0] fo;
        logic so, ov, un, na, irdy, ovld;
        fp_to_fixed_stream #(.INT_W(CFG_IW[g]), .FRAC_W(CFG_FW[g]), .ROUND(CFG_RD[g])) u_dut (
            .clk(clk), .rst(rst), .fp_i(fp), .in_valid_i(in_valid), .in_ready_o(irdy),
            .sign_o(so), .integer_o(io), .fractional_o(fo), .ovf_o(ov), .unf_o(un), .nan_o(na),
            .out_valid_o(ovld), .out_ready_i(out_ready));
        assign got_mag[g]  = 64'({io, fo});
        assign got_sign[g] = so;
        assign got_flg[g]  = {ov, un, na};
        assign got_ov[g]   = ovld;
        assign got_ir[g]   = irdy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    // Value = 1.m * 2^(e-127); scaled by 2^fw, integer quotient plus rounding on the remainder.
    function automatic ref_t ref_model(logic [31:0] f, int iw, int fw, int rnd);
        ref_t r;
        longint unsigned mant, m, q, rem, all1;
        int k, d;
        r.sign = f[31];
        r.mag  = '0;
        r.flg  = 3'b000;
        all1   = (64'd1 << (iw + fw)) - 64'd1;
        if (f[30:23] == 8'hFF) begin
            if (f[22:0] != 0) begin r.sign = 1'b0; r.flg = 3'b001; end
            else begin r.mag = all1; r.flg = 3'b100; end
            return r;
        end
        if (f[30:23] == 8'h00) begin
            if (f[22:0] != 0) r.flg = 3'b010;
            return r;
        end
        mant = {40'd0, 1'b1, f[22:0]};
        k = int'(f[30:23]) - 150 + fw;
        if (k >= 40) m = 64'hFFFF_FFFF_FFFF_FFFF;
        else if (k >= 0) m = mant << k;
        else begin
            d = -k;
            if (d >= 63) m = 0;
            else begin
                q   = mant >> d;
                rem = mant - (q << d);
                m   = q + (((rnd != 0) && (rem >= (64'd1 << (d - 1)))) ? 64'd1 : 64'd0);
            end
        end
        if (m > all1) begin r.mag = all1; r.flg = 3'b100; end
        else begin r.mag = m; if (m == 0) r.flg = 3'b010; end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] f;
        int sel;
        f   = $urandom;
        sel = $urandom_range(15, 0);
        case (sel)
            0: f[30:0] = '0;
            1: f[30:23] = 8'h00;
            2: begin f[30:23] = 8'hFF; f[22:0] = '0; end
            3: begin f[30:23] = 8'hFF; f[22] = 1'b1; end
            4: begin f[30:23] = 8'($urandom_range(140, 85)); f[15:0] = '0; end
            default: f[30:23] = 8'($urandom_range(140, 85));
        endcase
        return f;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: sample at negedge, score handshakes, return 1 time unit after posedge.
    task automatic cycle();
        logic [31:0] f;
        ref_t r;
        @(negedge clk);
        if (hold_prev) begin
            chk("hold_mag", got_mag[0], prev_mag);
            chk("hold_sign_flags", 64'({got_sign[0], got_flg[0]}), 64'(prev_sf));
        end
        if (got_ov[0] && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
            else begin
                f = sb_q.pop_front();
                for (int i = 0; i < NC; i++) begin
                    r = ref_model(f, CFG_IW[i], CFG_FW[i], CFG_RD[i]);
                    chk($sformatf("cfg%0d valid fp=%h", i, f), 64'(got_ov[i]), 64'd1);
                    chk($sformatf("cfg%0d ready fp=%h", i, f), 64'(got_ir[i]), 64'(got_ir[0]));
                    chk($sformatf("cfg%0d sign fp=%h", i, f), 64'(got_sign[i]), 64'(r.sign));
                    chk($sformatf("cfg%0d mag fp=%h", i, f), got_mag[i], r.mag);
                    chk($sformatf("cfg%0d flags fp=%h", i, f), 64'(got_flg[i]), 64'(r.flg));
                end
            end
        end
        if (in_valid && got_ir[0]) sb_q.push_back(fp);
        hold_prev = got_ov[0] && !out_ready;
        prev_mag  = got_mag[0];
        prev_sf   = {got_sign[0], got_flg[0]};
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 40 && sb_q.size() > 0; n++) cycle();
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int n0;
        rst = 1'b1; fp = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("rst_valid%0d", i), 64'(got_ov[i]), 64'd0);
            chk($sformatf("rst_out%0d", i), got_mag[i] | 64'({got_sign[i], got_flg[i]}), 64'd0);
        end
        chk("rst_in_ready", 64'(got_ir[0]), 64'd1);
        rst = 1'b0;

        // directed values, two cycles of latency each
        for (int j = 0; j < 8; j++) begin
            out_ready = 1'b1; fp = D_FP[j]; in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            cycle();
            chk($sformatf("dir%0d valid", j), 64'(got_ov[0]), 64'd1);
            chk($sformatf("dir%0d sign", j), 64'(got_sign[0]), 64'(D_S[j]));
            chk($sformatf("dir%0d mag_r0", j), got_mag[0], D_M0[j]);
            chk($sformatf("dir%0d flags_r0", j), 64'(got_flg[0]), 64'(D_F0[j]));
            chk($sformatf("dir%0d mag_r1", j), got_mag[1], D_M1[j]);
            chk($sformatf("dir%0d flags_r1", j), 64'(got_flg[1]), 64'(D_F1[j]));
        end
        drain();

        // backpressure: two accepted, third stalled, then three back-to-back deliveries
        out_ready = 1'b0; in_valid = 1'b1;
        fp = 32'h3F000000; cycle();
        fp = 32'hBF400000; cycle();
        fp = 32'h3FC00000;
        chk("bp_in_ready_low", 64'(got_ir[0]), 64'd0);
        cycle(); cycle();
        chk("bp_accepted", 64'(sb_q.size()), 64'd2);
        chk("bp_out_valid", 64'(got_ov[0]), 64'd1);
        out_ready = 1'b1;
        n0 = n_out;
        cycle();
        in_valid = 1'b0;
        cycle(); cycle();
        chk("bp_consecutive", 64'(n_out - n0), 64'd3);
        drain();

        // reset with two results in flight
        out_ready = 1'b0; in_valid = 1'b1;
        fp = 32'h3FC00000; cycle();
        fp = 32'hBF400000; cycle();
        in_valid = 1'b0;
        chk("inflight_valid", 64'(got_ov[0]), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(got_ov[0]), 64'd0);
        chk("async_rst_out", got_mag[0] | 64'({got_sign[0], got_flg[0]}), 64'd0);
        chk("async_rst_in_ready", 64'(got_ir[0]), 64'd1);
        sb_q.delete();
        hold_prev = 1'b0;
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (4) cycle();
        chk("no_stale_after_rst", 64'(n_out - n0), 64'd0);
        fp = 32'h3F000000; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("first_after_rst_valid", 64'(got_ov[0]), 64'd1);
        chk("first_after_rst_mag", got_mag[0], 64'h40000);
        drain();

        // random stream with random downstream stalls
        repeat (600) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            fp        = rand_fp();
            out_ready = ($urandom_range(2, 0) != 0);
            cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
